// File: rtl/pwm_deadtime_inserter.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_deadtime_inserter
//  Purpose  : Turns three single-ended SPWM commands (Va/Vb/Vc) into
//             complementary high/low gate pairs separated by a programmable
//             dead interval. The two gates of a leg are never high together.
//  Options  : DT_FAULT_INPUT_EN - adds a fault input that forces every leg
//             OFF and holds it there (sticky) until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_deadtime_inserter #(
    parameter int DEAD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
`ifdef DT_FAULT_INPUT_EN
    input  logic       fault,
    output logic       fault_latched,
`endif
    input  logic       Va,
    input  logic       Vb,
    input  logic       Vc,
    output logic       gA_h,
    output logic       gA_l,
    output logic       gB_h,
    output logic       gB_l,
    output logic       gC_h,
    output logic       gC_l,
    output logic [2:0] dead_active
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_DEAD_H = 3'd1,
        S_ON_H   = 3'd2,
        S_DEAD_L = 3'd3,
        S_ON_L   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [2:0] w_v;
    logic [2:0] w_gate_h;
    logic [2:0] w_gate_l;
    logic [2:0] w_dead;
    logic       w_force_off;
    logic       r_armed;

    assign w_v = {Vc, Vb, Va};

    // r_armed goes high one edge after reset release, so the first command
    // register load has happened before any leg leaves OFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

`ifdef DT_FAULT_INPUT_EN
    logic r_fault_latched;

    // Sticky fault latch: once set, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_latched <= 1'b0;
        end else if (fault) begin
            r_fault_latched <= 1'b1;
        end
    end

    assign w_force_off   = fault | r_fault_latched;
    assign fault_latched = r_fault_latched;
`else
    assign w_force_off = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_cmd;
            logic             r_gate_h;
            logic             r_gate_l;
            logic             r_dead;

            // Next-state and counter logic for one leg.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    S_OFF: begin
                        if (r_armed) begin
                            w_state_nxt = r_cmd ? S_DEAD_H : S_DEAD_L;
                            w_cnt_nxt   = c_LOAD;
                        end
                    end
                    S_DEAD_H: begin
                        if (!r_cmd) begin
                            w_state_nxt = S_DEAD_L;
                            w_cnt_nxt   = c_LOAD;
                        end else if (r_cnt == '0) begin
                            w_state_nxt = S_ON_H;
                        end else begin
                            w_cnt_nxt = r_cnt - c_ONE;
                        end
                    end
                    S_DEAD_L: begin
                        if (r_cmd) begin
                            w_state_nxt = S_DEAD_H;
                            w_cnt_nxt   = c_LOAD;
                        end else if (r_cnt == '0) begin
                            w_state_nxt = S_ON_L;
                        end else begin
                            w_cnt_nxt = r_cnt - c_ONE;
                        end
                    end
                    S_ON_H: begin
                        if (!r_cmd) begin
                            w_state_nxt = S_DEAD_L;
                            w_cnt_nxt   = c_LOAD;
                        end
                    end
                    S_ON_L: begin
                        if (r_cmd) begin
                            w_state_nxt = S_DEAD_H;
                            w_cnt_nxt   = c_LOAD;
                        end
                    end
                    default: begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = '0;
                    end
                endcase
                if (w_force_off) begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end
            end

            // State, counter, command and registered gate outputs.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state  <= S_OFF;
                    r_cnt    <= '0;
                    r_cmd    <= 1'b0;
                    r_gate_h <= 1'b0;
                    r_gate_l <= 1'b0;
                    r_dead   <= 1'b0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_cnt    <= w_cnt_nxt;
                    r_cmd    <= w_v[gi];
                    r_gate_h <= (w_state_nxt == S_ON_H);
                    r_gate_l <= (w_state_nxt == S_ON_L);
                    r_dead   <= (w_state_nxt == S_DEAD_H) ||
                                (w_state_nxt == S_DEAD_L);
                end
            end

            assign w_gate_h[gi] = r_gate_h;
            assign w_gate_l[gi] = r_gate_l;
            assign w_dead[gi]   = r_dead;
        end
    endgenerate

    assign gA_h        = w_gate_h[0];
    assign gA_l        = w_gate_l[0];
    assign gB_h        = w_gate_h[1];
    assign gB_l        = w_gate_l[1];
    assign gC_h        = w_gate_h[2];
    assign gC_l        = w_gate_l[2];
    assign dead_active = w_dead;

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_inserter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_deadtime_inserter
//  Purpose  : Self-checking bench for pwm_deadtime_inserter (DEAD_CYCLES=4).
//             A gate is expected on when its command has been sampled at the
//             same level on the last DEAD_CYCLES+1 edges since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_deadtime_inserter;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       Va    = 1'b0;
    logic       Vb    = 1'b0;
    logic       Vc    = 1'b0;
    logic       gA_h, gA_l, gB_h, gB_l, gC_h, gC_l;
    logic [2:0] dead_active;
`ifdef DT_FAULT_INPUT_EN
    logic       fault = 1'b0;
    logic       fault_latched;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: run lengths of identical command samples per phase.
    int run1 [3];
    int run0 [3];
    int n_since;
    bit m_flatch;

    pwm_deadtime_inserter #(.DEAD_CYCLES(D), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef DT_FAULT_INPUT_EN
        .fault       (fault),
        .fault_latched(fault_latched),
`endif
        .Va          (Va),
        .Vb          (Vb),
        .Vc          (Vc),
        .gA_h        (gA_h),
        .gA_l        (gA_l),
        .gB_h        (gB_h),
        .gB_l        (gB_l),
        .gC_h        (gC_h),
        .gC_l        (gC_l),
        .dead_active (dead_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample inputs at the edge, compare outputs 1 ns later
    // against the model, update the model, then return at the falling edge.
    task automatic step();
        logic [2:0] sv, eh, el, ed, dh, dl;
        logic       sr, sf, efl;
        @(posedge clk);
        sv  = {Vc, Vb, Va};
        sr  = reset;
        sf  = 1'b0;
`ifdef DT_FAULT_INPUT_EN
        sf  = fault;
`endif
        #1;
        eh  = '0;
        el  = '0;
        ed  = '0;
        efl = 1'b0;
        if (!sr) begin
            if (sf || m_flatch) begin
                efl = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    eh[i] = (run1[i] >= D + 1);
                    el[i] = (run0[i] >= D + 1);
                    ed[i] = (n_since >= 1) && !eh[i] && !el[i];
                end
            end
        end
        dh = {gC_h, gB_h, gA_h};
        dl = {gC_l, gB_l, gA_l};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gate_h[%0d]", i), int'(dh[i]), int'(eh[i]));
            chk($sformatf("gate_l[%0d]", i), int'(dl[i]), int'(el[i]));
            chk($sformatf("dead_active[%0d]", i), int'(dead_active[i]), int'(ed[i]));
            chk($sformatf("shoot_through[%0d]", i), int'(dh[i] & dl[i]), 0);
        end
`ifdef DT_FAULT_INPUT_EN
        chk("fault_latched", int'(fault_latched), int'(efl));
`endif
        if (sr) begin
            for (int i = 0; i < 3; i++) begin
                run1[i] = 0;
                run0[i] = 0;
            end
            n_since  = 0;
            m_flatch = 1'b0;
        end else if (sf || m_flatch) begin
            m_flatch = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sv[i]) begin
                    if (run1[i] < 1000) run1[i]++;
                    run0[i] = 0;
                end else begin
                    if (run0[i] < 1000) run0[i]++;
                    run1[i] = 0;
                end
            end
            if (n_since < 1000) n_since++;
        end
        @(negedge clk);
    endtask

    initial begin : stim
        int first_h;
        int dcnt;
        int hcnt;
        int lcnt;
        int ever_h;
        for (int i = 0; i < 3; i++) begin
            run1[i] = 0;
            run0[i] = 0;
        end
        n_since  = 0;
        m_flatch = 1'b0;

        // Reset release with Va held high.
        reset = 1'b1;
        Va    = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("reset_gates", int'({gA_h, gA_l, gB_h, gB_l, gC_h, gC_l}), 0);
        chk("reset_dead", int'(dead_active), 0);
        reset   = 1'b0;
        first_h = -1;
        dcnt    = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (gA_h && first_h < 0) first_h = i;
            if (dead_active[0]) dcnt++;
        end
        chk("release_gA_h_rise_step", first_h, 6);
        chk("release_deadA_cycles", dcnt, 4);

        // 40-cycle square wave on Va.
        for (int p = 0; p < 3; p++) begin
            hcnt = 0;
            lcnt = 0;
            for (int j = 0; j < 40; j++) begin
                Va = (j >= 20);
                step();
                if (gA_h) hcnt++;
                if (gA_l) lcnt++;
            end
            if (p > 0) begin
                chk($sformatf("square_gA_h_high_p%0d", p), hcnt, 16);
                chk($sformatf("square_gA_l_high_p%0d", p), lcnt, 16);
            end
        end

        // Vb 3-cycle pulse from steady low: swallowed.
        Vb     = 1'b1;
        ever_h = 0;
        lcnt   = 0;
        dcnt   = 0;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) Vb = 1'b0;
            step();
            if (gB_h) ever_h++;
            if (!gB_l) lcnt++;
            if (dead_active[1]) dcnt++;
        end
        chk("pulse_gB_h_never", ever_h, 0);
        chk("pulse_gB_l_low_cycles", lcnt, 7);
        chk("pulse_deadB_cycles", dcnt, 7);
        chk("pulse_gB_l_back", int'(gB_l), 1);

        // Reset in the middle of phase C's DEAD_H interval.
        Vc = 1'b1;
        for (int j = 0; j < 3; j++) step();
        chk("midC_in_dead", int'(dead_active[2]), 1);
        reset = 1'b1;
        step();
        chk("midC_reset_gates", int'({gA_h, gA_l, gB_h, gB_l, gC_h, gC_l}), 0);
        chk("midC_reset_dead", int'(dead_active), 0);
        reset   = 1'b0;
        first_h = -1;
        dcnt    = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (gC_h && first_h < 0) first_h = i;
            if (dead_active[2]) dcnt++;
        end
        chk("midC_gC_h_rise_step", first_h, 6);
        chk("midC_deadC_cycles", dcnt, 4);

        // Independent random toggling.
        for (int j = 0; j < 10000; j++) begin
            if ($urandom_range(0, 7) == 0) Va = ~Va;
            if ($urandom_range(0, 7) == 0) Vb = ~Vb;
            if ($urandom_range(0, 7) == 0) Vc = ~Vc;
            step();
        end

`ifdef DT_FAULT_INPUT_EN
        // One-cycle fault while gA_h is on.
        Va = 1'b1;
        for (int j = 0; j < 8; j++) step();
        chk("fault_pre_gA_h", int'(gA_h), 1);
        fault = 1'b1;
        step();
        fault = 1'b0;
        chk("fault_gates_off", int'({gA_h, gA_l, gB_h, gB_l, gC_h, gC_l}), 0);
        chk("fault_latched_set", int'(fault_latched), 1);
        for (int j = 0; j < 20; j++) begin
            if (j % 5 == 0) Va = ~Va;
            step();
        end
        chk("fault_latched_hold", int'(fault_latched), 1);
        chk("fault_gA_h_hold", int'(gA_h), 0);
        reset = 1'b1;
        step();
        chk("fault_latched_cleared", int'(fault_latched), 0);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
